uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//   Round-robin scheduler that shares one uart_transmitter between NREQ byte requesters.
//   Accepts one byte per grant, holds it on tx_data and drives tx_en for exactly one frame.
//   Frame completion comes from the transmitter's tx_txff_rd pulse, wired to tx_done.
//   Enforces a programmable idle gap between frames; sits between requesters and the transmitter.
// PARAMETERS
//   NREQ     4   number of requesters (2..8)
//   GAP_CYC  2   pclk cycles with tx_en low between frames (0 = no gap)
//   GW       4   gap counter width; GAP_CYC < 2**GW
// PORTS
//   pclk      in   1       clock
//   prst_n    in   1       reset, synchronous, active-low
//   sched_en  in   1       1 = scheduling enabled; 0 = abort current frame, grant nothing
//   req       in   NREQ    request vector; req[i] held until gnt[i]
//   req_data  in   8*NREQ  byte of requester i on req_data[8i+7:8i]
//   gnt       out  NREQ    one-hot 1-cycle pulse: byte of requester i accepted
//   done      out  NREQ    one-hot 1-cycle pulse: frame of requester i finished
//   abort     out  1       1-cycle pulse: frame killed by sched_en=0
//   owner     out  NREQ    one-hot owner of the frame in flight; 0 when not in SEND
//   tx_data   out  8       byte to transmitter apb_data
//   tx_en     out  1       to transmitter apb_tx_en
//   tx_done   in   1       from transmitter tx_txff_rd (1-cycle frame-complete)
// BEHAVIOUR
//   - All outputs are registered. Sync reset (prst_n=0 at a pclk edge) gives:
//     state=IDLE, tx_en=0, tx_data=8'h00, gnt=0, done=0, abort=0, owner=0, rr_ptr=0, gap_cnt=0.
//     Reset mid-frame drops tx_en on that edge; the in-flight byte is lost and no done/abort pulses.
//   - rr_ptr is the highest-priority index. The winner is the first i with req[i]=1,
//     searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   - IDLE: if sched_en & |req, at the next edge: tx_data<=req_data[winner], owner<=onehot(winner),
//     gnt[winner]=1 for one cycle, tx_en<=1, go to SEND. Otherwise stay in IDLE.
//     Grant latency is 1 cycle from a request sampled in IDLE.
//   - SEND: tx_en=1; tx_data and owner are stable.
//     tx_done=1: next edge tx_en<=0, done[owner] pulses, rr_ptr<=owner+1 mod NREQ, owner<=0;
//     go to GAP (gap_cnt<=GAP_CYC-1), or to IDLE if GAP_CYC=0.
//     sched_en=0 with tx_done=0: next edge tx_en<=0, abort pulses, rr_ptr<=owner+1, owner<=0, go to IDLE.
//     tx_done=1 and sched_en=0 in the same cycle: completion wins; done pulses, abort does not.
//     tx_done outside SEND is ignored.
//   - GAP: tx_en=0, no grants. gap_cnt decrements each cycle; at gap_cnt=0 go to IDLE.
//     Requests asserted during GAP wait and are arbitrated in IDLE.
//     sched_en=0 in GAP has no extra effect.
//   - Minimum spacing: tx_en is low for GAP_CYC+1 cycles between frames (GAP cycles plus the IDLE cycle).
//   - tx_data keeps its last value outside SEND; the transmitter ignores it while tx_en=0.
//   - gnt, done and abort are never asserted in the same cycle as each other for the same index.
//     At most one bit of gnt is set, and at most one bit of done is set.
// TESTING
//   1 Reset, sched_en=1, req=4'b0010, data1=8'hA5 -> gnt=4'b0010 one cycle later, tx_data=8'hA5, tx_en=1;
//     tx_done pulse -> done=4'b0010 next cycle, tx_en=0 for 3 cycles (GAP_CYC=2) before the next grant.
//   2 req=4'b1111 held continuously with data 8'h10..8'h13 -> grant order 0,1,2,3,0;
//     tx_data follows 8'h10,8'h11,8'h12,8'h13,8'h10.
//   3 After a grant to 1, req=4'b0101 -> next grant 2, then 0.
//   4 sched_en=0 mid-SEND (owner 3) -> tx_en=0 and abort=1 next cycle, no done;
//     with sched_en=1 and req=4'b1001 the next grant is 0.
//   5 tx_done=1 and sched_en=0 in the same cycle -> done[owner]=1, abort=0, state goes to GAP.
//   6 prst_n=0 for one edge mid-SEND -> all outputs at reset values next cycle;
//     req=4'b1010 then grants 1 first (rr_ptr=0).

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin scheduler sharing one UART transmitter between NREQ byte
//   requesters. A granted byte is held on tx_data while tx_en is high for
//   exactly one frame; the transmitter's frame-complete pulse (tx_done) ends
//   the frame, after which tx_en stays low for GAP_CYC cycles plus one IDLE
//   cycle before the next grant.
// Ports
//   pclk      in   clock
//   prst_n    in   synchronous active-low reset
//   sched_en  in   1 = scheduling enabled; 0 = abort frame in flight, no grants
//   req       in   [NREQ]   request vector, req[i] held until gnt[i]
//   req_data  in   [8*NREQ] byte of requester i on req_data[8i+7:8i]
//   gnt       out  [NREQ]   one-hot 1-cycle pulse: byte of requester i accepted
//   done      out  [NREQ]   one-hot 1-cycle pulse: frame of requester i finished
//   abort     out           1-cycle pulse: frame killed by sched_en=0
//   owner     out  [NREQ]   one-hot owner of the frame in flight, 0 outside SEND
//   tx_data   out  [8]      byte to transmitter
//   tx_en     out           transmit enable to transmitter
//   tx_done   in            1-cycle frame-complete pulse from transmitter
module uart_tx_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned GW      = 4
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              sched_en,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              abort,
    output logic [NREQ-1:0]   owner,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    input  logic              tx_done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYC == 0) ? '0 : GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            abort_q, abort_d;
    logic [NREQ-1:0] owner_q, owner_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_en_q, tx_en_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   own_idx_q, own_idx_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [7:0]      win_byte;
    logic [PW-1:0]   rr_after_owner;

    // First requester found scanning upward from rr_q, wrapping at NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_byte  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned   cand;
            logic [PW-1:0] cand_idx;
            cand     = (32'(rr_q) + k) % NREQ;
            cand_idx = PW'(cand);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
                win_byte  = req_data[8*cand +: 8];
            end
        end
    end

    assign rr_after_owner = (own_idx_q == PW'(NREQ - 1)) ? '0 : own_idx_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        done_d    = '0;
        abort_d   = 1'b0;
        owner_d   = owner_q;
        tx_data_d = tx_data_q;
        tx_en_d   = tx_en_q;
        rr_d      = rr_q;
        own_idx_d = own_idx_q;
        gap_d     = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (sched_en && win_found) begin
                    tx_data_d = win_byte;
                    owner_d   = NREQ'(1) << win_idx;
                    gnt_d     = NREQ'(1) << win_idx;
                    own_idx_d = win_idx;
                    tx_en_d   = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                // Completion takes precedence over a simultaneous abort.
                if (tx_done) begin
                    tx_en_d = 1'b0;
                    done_d  = owner_q;
                    rr_d    = rr_after_owner;
                    owner_d = '0;
                    if (GAP_CYC == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end else if (!sched_en) begin
                    tx_en_d = 1'b0;
                    abort_d = 1'b1;
                    rr_d    = rr_after_owner;
                    owner_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            abort_q   <= 1'b0;
            owner_q   <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            rr_q      <= '0;
            own_idx_q <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            rr_q      <= rr_d;
            own_idx_q <= own_idx_d;
            gap_q     <= gap_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign abort   = abort_q;
    assign owner   = owner_q;
    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    logic        pclk;
    logic        prst_n;
    logic        sched_en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        abort;
    logic [3:0]  owner;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_done;

    int checks;
    int errors;

    uart_tx_sched #(
        .NREQ    (4),
        .GAP_CYC (2),
        .GW      (4)
    ) dut (
        .pclk     (pclk),
        .prst_n   (prst_n),
        .sched_en (sched_en),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .abort    (abort),
        .owner    (owner),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_done  (tx_done)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_en"},   32'(tx_en),   32'h0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'h00);
        chk({tag, "_gnt"},     32'(gnt),     32'h0);
        chk({tag, "_done"},    32'(done),    32'h0);
        chk({tag, "_abort"},   32'(abort),   32'h0);
        chk({tag, "_owner"},   32'(owner),   32'h0);
    endtask

    // Bounded wait for a grant, then check it and the accepted byte.
    task automatic wait_gnt(input int idx, input logic [7:0] d);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt === 4'b0000 && n < 16);
        chk("gnt",     32'(gnt),     32'(1) << idx);
        chk("tx_data", 32'(tx_data), 32'(d));
        chk("tx_en",   32'(tx_en),   32'h1);
        chk("owner",   32'(owner),   32'(1) << idx);
    endtask

    task automatic finish_frame(input int idx);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("done",       32'(done),  32'(1) << idx);
        chk("done_tx_en", 32'(tx_en), 32'h0);
        chk("done_abort", 32'(abort), 32'h0);
        chk("done_owner", 32'(owner), 32'h0);
    endtask

    task automatic frame(input int idx, input logic [7:0] d);
        wait_gnt(idx, d);
        finish_frame(idx);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        prst_n   = 1'b0;
        sched_en = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;
        tx_done  = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");

        // tx_done outside SEND must be ignored
        prst_n   = 1'b1;
        sched_en = 1'b1;
        tx_done  = 1'b1;
        tick();
        tx_done  = 1'b0;
        chk("idle_txdone_done", 32'(done),  32'h0);
        chk("idle_txdone_en",   32'(tx_en), 32'h0);

        // Test 1: single request, 1-cycle grant latency, gap of 3 low cycles
        req      = 4'b0010;
        req_data = 32'h0000A500;
        tick();
        chk("t1_gnt",     32'(gnt),     32'h2);
        chk("t1_tx_data", 32'(tx_data), 32'hA5);
        chk("t1_tx_en",   32'(tx_en),   32'h1);
        req = 4'b0000;
        tick();
        chk("t1_gnt_pulse", 32'(gnt),   32'h0);
        chk("t1_en_held",   32'(tx_en), 32'h1);
        finish_frame(1);
        req      = 4'b0001;
        req_data = 32'h0000A55A;
        tick();
        chk("t1_gap1_en",  32'(tx_en), 32'h0);
        chk("t1_gap1_gnt", 32'(gnt),   32'h0);
        tick();
        chk("t1_gap2_en",  32'(tx_en), 32'h0);
        chk("t1_gap2_gnt", 32'(gnt),   32'h0);
        tick();
        chk("t1_next_gnt", 32'(gnt),     32'h1);
        chk("t1_next_dat", 32'(tx_data), 32'h5A);
        req = 4'b0000;
        finish_frame(0);

        // Test 2: all requesting, round robin 0,1,2,3,0
        prst_n = 1'b0;
        tick();
        prst_n   = 1'b1;
        req      = 4'b1111;
        req_data = 32'h13121110;
        frame(0, 8'h10);
        frame(1, 8'h11);
        frame(2, 8'h12);
        frame(3, 8'h13);
        frame(0, 8'h10);

        // Test 3: after grant to 1, req=0101 -> 2 then 0
        req = 4'b0010;
        wait_gnt(1, 8'h11);
        req = 4'b0101;
        finish_frame(1);
        frame(2, 8'h12);
        frame(0, 8'h10);

        // Test 4: abort while owner 3 is sending
        req = 4'b1000;
        wait_gnt(3, 8'h13);
        req      = 4'b0000;
        sched_en = 1'b0;
        tick();
        chk("t4_abort", 32'(abort), 32'h1);
        chk("t4_tx_en", 32'(tx_en), 32'h0);
        chk("t4_done",  32'(done),  32'h0);
        chk("t4_owner", 32'(owner), 32'h0);
        sched_en = 1'b1;
        req      = 4'b1001;
        tick();
        chk("t4_abort_pulse", 32'(abort), 32'h0);
        chk("t4_next_gnt",    32'(gnt),   32'h1);
        req = 4'b1000;
        finish_frame(0);

        // Test 5: tx_done and sched_en=0 together -> done wins, GAP follows
        wait_gnt(3, 8'h13);
        tx_done  = 1'b1;
        sched_en = 1'b0;
        tick();
        tx_done  = 1'b0;
        sched_en = 1'b1;
        req      = 4'b1001;
        chk("t5_done",  32'(done),  32'h8);
        chk("t5_abort", 32'(abort), 32'h0);
        chk("t5_tx_en", 32'(tx_en), 32'h0);
        tick();
        chk("t5_gap1_gnt", 32'(gnt), 32'h0);
        tick();
        chk("t5_gap2_gnt", 32'(gnt), 32'h0);
        tick();
        chk("t5_gnt", 32'(gnt), 32'h1);
        req = 4'b0100;
        finish_frame(0);

        // Test 6: reset mid-SEND with rr_ptr away from 0
        wait_gnt(2, 8'h12);
        req = 4'b1000;
        finish_frame(2);
        wait_gnt(3, 8'h13);
        req    = 4'b0000;
        prst_n = 1'b0;
        tick();
        chk_reset_outputs("t6_reset");
        prst_n = 1'b1;
        req    = 4'b1010;
        tick();
        chk("t6_gnt",     32'(gnt),     32'h2);
        chk("t6_tx_data", 32'(tx_data), 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
